// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
package alu_nibble_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } seq_state_e;

    // 74181 function select/mode pair as presented on S[3:0] and M.
    typedef struct packed {
        logic [3:0] s;
        logic       m;
    } alu_fn_t;

    // Common functions (active-high data convention).
    localparam alu_fn_t FN_ADD  = '{s: 4'b1001, m: 1'b0};
    localparam alu_fn_t FN_SUB  = '{s: 4'b0110, m: 1'b0};
    localparam alu_fn_t FN_AND  = '{s: 4'b1011, m: 1'b1};
    localparam alu_fn_t FN_OR   = '{s: 4'b1110, m: 1'b1};
    localparam alu_fn_t FN_XOR  = '{s: 4'b0110, m: 1'b1};
    localparam alu_fn_t FN_ZERO = '{s: 4'b0011, m: 1'b1};

    // Idle value parked on the slice function pins: S = 0, logic mode.
    localparam alu_fn_t FN_IDLE = '{s: 4'b0000, m: 1'b1};

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Drives one external 74181 slice nibble-serially (LS nibble first) to
// perform a WIDTH-bit operation. Each nibble is held for SETTLE_CYCLES
// clocks so the slow combinational slice can settle before its F, CN+4
// and A=B outputs are sampled. The active-low ripple carry is chained
// between nibbles through the alu_cn_n output register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; slice inputs hold their last value
// ST_SETTLE | nibble idx on the slice; cnt counts settle clocks
// ST_DONE   | one-cycle done pulse; a start here is accepted
module alu_nibble_sequencer
    import alu_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             cin_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_n,
    output logic             aeb,
    output logic             zero,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cn_n,
    input  logic [3:0]       alu_f,
    input  logic             alu_cn4_n,
    input  logic             alu_aeb
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_e       state_q,    state_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             acc_q,      acc_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             cout_n_q,   cout_n_d;
    logic             aeb_q,      aeb_d;
    logic             zero_q,     zero_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [3:0]       alu_a_q,    alu_a_d;
    logic [3:0]       alu_b_q,    alu_b_d;
    logic [3:0]       alu_s_q,    alu_s_d;
    logic             alu_m_q,    alu_m_d;
    logic             alu_cn_n_q, alu_cn_n_d;

    logic [IDX_W-1:0] idx_nxt;

    // State, operand latches, counters and every output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            result_q   <= '0;
            cout_n_q   <= 1'b1;
            aeb_q      <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            alu_a_q    <= 4'h0;
            alu_b_q    <= 4'h0;
            alu_s_q    <= FN_IDLE.s;
            alu_m_q    <= FN_IDLE.m;
            alu_cn_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            cout_n_q   <= cout_n_d;
            aeb_q      <= aeb_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_s_q    <= alu_s_d;
            alu_m_q    <= alu_m_d;
            alu_cn_n_q <= alu_cn_n_d;
        end
    end

    // Next-state, settle timing, nibble mux and result assembly.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        result_d   = result_q;
        cout_n_d   = cout_n_q;
        aeb_d      = aeb_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_s_d    = alu_s_q;
        alu_m_d    = alu_m_q;
        alu_cn_n_d = alu_cn_n_q;
        idx_nxt    = idx_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    alu_a_d    = op_a[3:0];
                    alu_b_d    = op_b[3:0];
                    alu_s_d    = op_s;
                    alu_m_d    = op_m;
                    alu_cn_n_d = cin_n;
                    idx_d      = '0;
                    cnt_d      = '0;
                    acc_d      = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Capture edge: slice outputs have settled for this nibble.
                    result_d[{idx_q, 2'b00} +: 4] = alu_f;
                    acc_d = acc_q & alu_aeb;
                    if (idx_q != IDX_LAST) begin
                        // Carry into the next nibble comes straight from CN+4;
                        // it is chained in logic mode too, where F ignores it.
                        idx_d      = idx_nxt;
                        cnt_d      = '0;
                        alu_a_d    = a_q[{idx_nxt, 2'b00} +: 4];
                        alu_b_d    = b_q[{idx_nxt, 2'b00} +: 4];
                        alu_cn_n_d = alu_cn4_n;
                    end else begin
                        cout_n_d = alu_cn4_n;
                        aeb_d    = acc_q & alu_aeb;
                        zero_d   = (result_d == '0);
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout_n   = cout_n_q;
    assign aeb      = aeb_q;
    assign zero     = zero_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_s    = alu_s_q;
    assign alu_m    = alu_m_q;
    assign alu_cn_n = alu_cn_n_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a delayed 74181 slice model sits on the
// alu_* pins; expected results come from whole-word arithmetic.
module tb_alu_nibble_sequencer;

    localparam int W   = 16;
    localparam int SC  = 8;
    localparam int NIB = W / 4;
    localparam int LAT = NIB * SC;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_ZERO = 5;

    logic [3:0] op_sel [6] = '{4'b1001, 4'b0110, 4'b1011, 4'b1110, 4'b0110, 4'b0011};
    logic       op_mode[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    string      op_name[6] = '{"add", "sub", "and", "or", "xor", "zero"};

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         cin_n;
    logic         busy, done;
    logic [W-1:0] result;
    logic         cout_n, aeb, zero;
    logic [3:0]   alu_a, alu_b, alu_s;
    logic         alu_m, alu_cn_n;
    logic [3:0]   alu_f;
    logic         alu_cn4_n, alu_aeb;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         cout_n;
        bit           chk_cout;
        logic         aeb;
        logic         zero;
        int           done_edge;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    int   done_cnt = 0;
    int   pushed = 0;
    int   last_done_edge = 0;

    alu_nibble_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .cin_n(cin_n),
        .busy(busy), .done(done), .result(result), .cout_n(cout_n),
        .aeb(aeb), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_cn_n(alu_cn_n), .alu_f(alu_f), .alu_cn4_n(alu_cn4_n),
        .alu_aeb(alu_aeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // 74181 slice, active-high data; returns {CN+4_n, A=B, F}.
    function automatic logic [5:0] s181(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s, input logic m,
                                        input logic cn_n);
        logic [4:0] a5, b5, nb5, ab, anb, aob, aonb, m1, ci, x;
        logic [3:0] f;
        a5 = {1'b0, a};  b5 = {1'b0, b};  nb5 = {1'b0, ~b};
        ab = {1'b0, a & b};  anb = {1'b0, a & ~b};
        aob = {1'b0, a | b}; aonb = {1'b0, a | ~b};
        m1 = 5'h0F;  ci = {4'b0000, ~cn_n};
        case (s)
            4'h0: x = a5 + ci;
            4'h1: x = aob + ci;
            4'h2: x = aonb + ci;
            4'h3: x = m1 + ci;
            4'h4: x = a5 + anb + ci;
            4'h5: x = aob + anb + ci;
            4'h6: x = a5 + nb5 + ci;
            4'h7: x = anb + m1 + ci;
            4'h8: x = a5 + ab + ci;
            4'h9: x = a5 + b5 + ci;
            4'hA: x = aonb + ab + ci;
            4'hB: x = ab + m1 + ci;
            4'hC: x = a5 + a5 + ci;
            4'hD: x = aob + a5 + ci;
            4'hE: x = aonb + a5 + ci;
            default: x = a5 + m1 + ci;
        endcase
        case (s)
            4'h0: f = ~a;
            4'h1: f = ~(a | b);
            4'h2: f = ~a & b;
            4'h3: f = 4'h0;
            4'h4: f = ~(a & b);
            4'h5: f = ~b;
            4'h6: f = a ^ b;
            4'h7: f = a & ~b;
            4'h8: f = ~a | b;
            4'h9: f = ~(a ^ b);
            4'hA: f = b;
            4'hB: f = a & b;
            4'hC: f = 4'hF;
            4'hD: f = a | ~b;
            4'hE: f = a | b;
            default: f = a;
        endcase
        if (!m) f = x[3:0];
        return {~x[4], &f, f};
    endfunction

    logic [5:0] slice_out;
    assign #70 slice_out = s181(alu_a, alu_b, alu_s, alu_m, alu_cn_n);
    assign alu_f     = slice_out[3:0];
    assign alu_aeb   = slice_out[4];
    assign alu_cn4_n = slice_out[5];

    // Whole-word reference for one operation.
    function automatic exp_t model(input int op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t       e;
        logic [W:0] sum;
        logic [W:0] cy;
        cy = {{W{1'b0}}, ~cin};
        e.name = op_name[op];
        e.chk_cout = 1'b0;
        e.cout_n = 1'b1;
        sum = '0;
        case (op)
            OP_ADD: begin sum = {1'b0, a} + {1'b0, b} + cy;  e.chk_cout = 1'b1; end
            OP_SUB: begin sum = {1'b0, a} + {1'b0, ~b} + cy; e.chk_cout = 1'b1; end
            OP_AND: sum = {1'b0, a & b};
            OP_OR:  sum = {1'b0, a | b};
            OP_XOR: sum = {1'b0, a ^ b};
            default: sum = '0;
        endcase
        e.res = sum[W-1:0];
        if (e.chk_cout) e.cout_n = ~sum[W];
        e.aeb = (e.res == {W{1'b1}});
        e.zero = (e.res == '0);
        e.done_edge = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 at edge %0d, required no done", edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_result"}, 32'(result), 32'(e.res));
                    check({e.name, "_aeb"}, 32'(aeb), 32'(e.aeb));
                    check({e.name, "_zero"}, 32'(zero), 32'(e.zero));
                    check({e.name, "_busy_low"}, 32'(busy), 32'd0);
                    check({e.name, "_done_edge"}, 32'(edge_cnt), 32'(e.done_edge));
                    if (e.chk_cout) check({e.name, "_cout_n"}, 32'(cout_n), 32'(e.cout_n));
                end
            end
        end
    end

    // Issue one operation at the next edge the sequencer can accept it.
    task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input bit expect_done, output int acc_edge);
        exp_t e;
        while (edge_cnt < last_done_edge) @(negedge clk);
        op_a = a; op_b = b; op_s = op_sel[op]; op_m = op_mode[op]; cin_n = cin;
        start = 1'b1;
        acc_edge = edge_cnt + 1;
        last_done_edge = acc_edge + LAT;
        if (expect_done) begin
            e = model(op, a, b, cin);
            e.done_edge = acc_edge + LAT;
            exp_q.push_back(e);
            pushed++;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_result"},   32'(result),   32'd0);
        check({tag, "_cout_n"},   32'(cout_n),   32'd1);
        check({tag, "_aeb"},      32'(aeb),      32'd0);
        check({tag, "_zero"},     32'(zero),     32'd0);
        check({tag, "_alu_a"},    32'(alu_a),    32'd0);
        check({tag, "_alu_b"},    32'(alu_b),    32'd0);
        check({tag, "_alu_s"},    32'(alu_s),    32'd0);
        check({tag, "_alu_m"},    32'(alu_m),    32'd1);
        check({tag, "_alu_cn_n"}, 32'(alu_cn_n), 32'd1);
    endtask

    initial begin
        int           acc;
        int           op;
        int           seen;
        logic [W-1:0] ra, rb;
        exp_t         e1, e2;

        reset_n = 1'b0; start = 1'b0;
        op_a = '0; op_b = '0; op_s = 4'h0; op_m = 1'b0; cin_n = 1'b1;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        last_done_edge = edge_cnt;

        run_op(OP_ADD, 16'h1234, 16'h0FFF, 1'b1, 1'b1, acc);
        run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b1, acc);
        run_op(OP_SUB, 16'h5555, 16'h5555, 1'b1, 1'b1, acc);
        run_op(OP_SUB, 16'h5555, 16'h5554, 1'b1, 1'b1, acc);
        run_op(OP_ADD, 16'h7FFF, 16'h0000, 1'b0, 1'b1, acc);

        // AND then XOR back-to-back with start held through the DONE cycle.
        while (edge_cnt < last_done_edge) @(negedge clk);
        op_a = 16'hF0F0; op_b = 16'h3C3C; op_s = op_sel[OP_AND]; op_m = op_mode[OP_AND];
        cin_n = 1'b1; start = 1'b1;
        acc = edge_cnt + 1;
        e1 = model(OP_AND, 16'hF0F0, 16'h3C3C, 1'b1);
        e1.done_edge = acc + LAT;
        e2 = model(OP_XOR, 16'hFFFF, 16'h00FF, 1'b1);
        e2.done_edge = acc + LAT + 1 + LAT;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        pushed += 2;
        @(negedge clk);
        op_a = 16'hFFFF; op_b = 16'h00FF; op_s = op_sel[OP_XOR]; op_m = op_mode[OP_XOR];
        while (edge_cnt < acc + LAT + 1) @(negedge clk);
        start = 1'b0;
        last_done_edge = e2.done_edge;

        // Starts while busy are ignored.
        run_op(OP_ADD, 16'h0F0F, 16'h0101, 1'b0, 1'b1, acc);
        while (edge_cnt < acc + 4) @(negedge clk);
        op_a = 16'hAAAA; op_b = 16'h1111; op_s = op_sel[OP_OR]; op_m = op_mode[OP_OR];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < acc + 9) @(negedge clk);
        op_a = 16'h0000; op_b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < last_done_edge + 2 * LAT) @(negedge clk);
        check("ignored_start_done_count", 32'(done_cnt), 32'(pushed));

        // Reset mid-operation aborts with no done.
        run_op(OP_ADD, 16'hABCD, 16'h1111, 1'b1, 1'b0, acc);
        while (edge_cnt < acc + 12) @(negedge clk);
        seen = done_cnt;
        reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        reset_n = 1'b1;
        last_done_edge = edge_cnt;
        repeat (2 * LAT) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(seen));
        last_done_edge = edge_cnt;

        run_op(OP_ADD, 16'h0001, 16'h0002, 1'b1, 1'b1, acc);
        run_op(OP_ZERO, 16'hBEEF, 16'hCAFE, 1'b0, 1'b1, acc);

        // Randomized operations with random gaps.
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 5));
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = (op == OP_SUB) ? ra : ~ra;
            run_op(op, ra, rb, 1'($urandom_range(0, 1)), 1'b1, acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int i = 0; i < 3 * LAT && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("total_done_count", 32'(done_cnt), 32'(pushed));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
